// File: rtl/mnist_image_scanner.sv
// Raster-scans the 28x28 drawing grid out of image_memory and streams binarised pixels
// on a valid/ready port. Reports done and the count of set pixels at the end of each scan.
module mnist_image_scanner #(
  parameter int                            GRID_SIZE  = 28,
  parameter int                            ADDR_WIDTH = 16,
  parameter int                            DATA_WIDTH = 32,
  parameter logic signed [DATA_WIDTH-1:0]  PIXEL_ONE  = 1
) (
  input  logic                         CLOCK_50,
  input  logic                         resetn,
  input  logic                         start,
  output logic [ADDR_WIDTH-1:0]        read_addr,
  input  logic [DATA_WIDTH-1:0]        mem_data,
  output logic signed [DATA_WIDTH-1:0] pix_data,
  output logic [9:0]                   pix_index,
  output logic                         pix_valid,
  input  logic                         pix_ready,
  output logic                         pix_last,
  output logic                         busy,
  output logic                         done,
  output logic [9:0]                   set_count
);

  localparam int         N     = GRID_SIZE * GRID_SIZE;
  localparam logic [9:0] LAST  = 10'(N - 1);

  // state   | meaning
  // IDLE    | waiting for start
  // ADDR    | read_addr holds idx; memory is reading
  // LATCH   | mem_data valid; binarise and count
  // PRESENT | pixel offered until pix_ready
  // DONE    | one-cycle done pulse; publish set_count
  typedef enum logic [2:0] {S_IDLE, S_ADDR, S_LATCH, S_PRESENT, S_DONE} state_t;

  state_t                         state_q, state_d;
  logic [9:0]                     idx_q, idx_d;
  logic [9:0]                     cnt_q, cnt_d;
  logic [ADDR_WIDTH-1:0]          read_addr_q, read_addr_d;
  logic signed [DATA_WIDTH-1:0]   pix_data_q, pix_data_d;
  logic [9:0]                     pix_index_q, pix_index_d;
  logic                           pix_valid_q, pix_valid_d;
  logic                           pix_last_q, pix_last_d;
  logic [9:0]                     set_count_q, set_count_d;

  always_ff @(posedge CLOCK_50 or negedge resetn) begin
    if (!resetn) begin
      state_q     <= S_IDLE;
      idx_q       <= '0;
      cnt_q       <= '0;
      read_addr_q <= '0;
      pix_data_q  <= '0;
      pix_index_q <= '0;
      pix_valid_q <= 1'b0;
      pix_last_q  <= 1'b0;
      set_count_q <= '0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      cnt_q       <= cnt_d;
      read_addr_q <= read_addr_d;
      pix_data_q  <= pix_data_d;
      pix_index_q <= pix_index_d;
      pix_valid_q <= pix_valid_d;
      pix_last_q  <= pix_last_d;
      set_count_q <= set_count_d;
    end
  end

  // read_addr is loaded on entry to ADDR so the address is already on the port during ADDR.
  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    cnt_d       = cnt_q;
    read_addr_d = read_addr_q;
    pix_data_d  = pix_data_q;
    pix_index_d = pix_index_q;
    pix_valid_d = pix_valid_q;
    pix_last_d  = pix_last_q;
    set_count_d = set_count_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          idx_d       = '0;
          cnt_d       = '0;
          read_addr_d = '0;
          state_d     = S_ADDR;
        end
      end
      S_ADDR: state_d = S_LATCH;
      S_LATCH: begin
        pix_data_d  = (mem_data != '0) ? PIXEL_ONE : '0;
        pix_index_d = idx_q;
        pix_last_d  = (idx_q == LAST);
        pix_valid_d = 1'b1;
        if (mem_data != '0) cnt_d = cnt_q + 10'd1;
        state_d     = S_PRESENT;
      end
      S_PRESENT: begin
        if (pix_ready) begin
          pix_valid_d = 1'b0;
          if (idx_q == LAST) begin
            state_d = S_DONE;
          end else begin
            idx_d       = idx_q + 10'd1;
            read_addr_d = ADDR_WIDTH'(idx_q + 10'd1);
            state_d     = S_ADDR;
          end
        end
      end
      S_DONE: begin
        set_count_d = cnt_q;
        state_d     = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign read_addr = read_addr_q;
  assign pix_data  = pix_data_q;
  assign pix_index = pix_index_q;
  assign pix_valid = pix_valid_q;
  assign pix_last  = pix_last_q;
  assign set_count = set_count_q;
  assign busy      = (state_q != S_IDLE);
  assign done      = (state_q == S_DONE);

endmodule

// File: tb/tb_mnist_image_scanner.sv
// Directed bench for mnist_image_scanner with a synchronous-read image memory model.
module tb_mnist_image_scanner;
  logic               clk = 1'b0;
  logic               resetn, start, pix_ready;
  logic [15:0]        read_addr;
  logic signed [31:0] mem_data, pix_data;
  logic [9:0]         pix_index, set_count;
  logic               pix_valid, pix_last, busy, done;

  logic signed [31:0] mem [0:783];

  int checks = 0, failures = 0;
  int bp_idx, bp_len, restart_at, reset_at, hold_sc;
  bit start_on_done;
  int done_cyc, first_valid, n_xfer, bad_idx, bad_data, bad_last, bad_hold, n_done;
  int bp_stable, idle_bad, rst_nonzero, timed_out;

  mnist_image_scanner dut (
    .CLOCK_50 (clk),
    .resetn   (resetn),
    .start    (start),
    .read_addr(read_addr),
    .mem_data (mem_data),
    .pix_data (pix_data),
    .pix_index(pix_index),
    .pix_valid(pix_valid),
    .pix_ready(pix_ready),
    .pix_last (pix_last),
    .busy     (busy),
    .done     (done),
    .set_count(set_count)
  );

  always #5 clk = ~clk;

  always @(posedge clk) mem_data <= (read_addr < 16'd784) ? mem[read_addr] : 32'sd0;

  function automatic logic signed [31:0] exp_pix(input int i);
    return (mem[i] != 0) ? 32'sd1 : 32'sd0;
  endfunction

  task automatic chk(input string tag, input logic [79:0] obs, input logic [79:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic clear_knobs();
    bp_idx = -1; bp_len = 0; restart_at = -1; reset_at = -1; hold_sc = -1; start_on_done = 0;
  endtask

  // One scan: start pulse in cycle 0, sample #1 after every edge (sample k = cycle k).
  task automatic scan();
    int k, exp_idx, bp_left, post;
    done_cyc = -1; first_valid = -1; bad_idx = 0; bad_data = 0; bad_last = 0; bad_hold = 0;
    n_done = 0; bp_stable = 0; idle_bad = 0; rst_nonzero = 0; timed_out = 0;
    k = 0; exp_idx = 0; bp_left = bp_len; post = -1;
    @(negedge clk);
    start = 1'b1; pix_ready = 1'b1;
    while (k < 6000 && post != 0) begin
      @(posedge clk); #1;
      k++;
      start = 1'b0; pix_ready = 1'b1;
      if (done) begin
        n_done++;
        if (done_cyc < 0) done_cyc = k;
      end
      if (hold_sc >= 0 && done_cyc < 0 && set_count !== 10'(hold_sc)) bad_hold++;
      if (post > 0) begin
        if (post == 3 && busy) idle_bad++;
        post--;
      end else if (done) begin
        post = 3;
        if (start_on_done) start = 1'b1;
      end
      if (pix_valid) begin
        if (first_valid < 0) first_valid = k;
        if (exp_idx == reset_at) begin
          resetn = 1'b0;
          #1;
          if ({read_addr, pix_data, pix_index, pix_valid, pix_last, busy, done, set_count} !== '0)
            rst_nonzero++;
          @(negedge clk); resetn = 1'b1;
          repeat (12) begin
            @(posedge clk); #1;
            if (done || busy) n_done++;
          end
          n_xfer = exp_idx;
          return;
        end
        if (bp_left > 0 && pix_index == 10'(bp_idx)) begin
          pix_ready = 1'b0;
          bp_left--;
          if (pix_data === exp_pix(bp_idx) && pix_last === 1'b0) bp_stable++;
        end else begin
          if (pix_index !== 10'(exp_idx)) bad_idx++;
          if (pix_data !== exp_pix(exp_idx)) bad_data++;
          if (pix_last !== (exp_idx == 783)) bad_last++;
          if (exp_idx == restart_at) start = 1'b1;
          exp_idx++;
        end
      end
    end
    n_xfer = exp_idx;
    if (k >= 6000) timed_out = 1;
  endtask

  initial begin
    resetn = 1'b0; start = 1'b0; pix_ready = 1'b0;
    for (int i = 0; i < 784; i++) mem[i] = 32'sd0;
    clear_knobs();
    #12;
    chk("reset_outputs",
        80'({read_addr, pix_data, pix_index, pix_valid, pix_last, busy, done, set_count}), 80'd0);
    @(negedge clk); resetn = 1'b1;

    // T1: all-zero image
    scan();
    chk("t1_timeout", timed_out, 0);
    chk("t1_xfers", n_xfer, 784);
    chk("t1_index", bad_idx, 0);
    chk("t1_data", bad_data, 0);
    chk("t1_last", bad_last, 0);
    chk("t1_first_valid", first_valid, 3);
    chk("t1_done_cycle", done_cyc, 2353);
    chk("t1_done_count", n_done, 1);
    chk("t1_idle_after", idle_bad, 0);
    chk("t1_set_count", set_count, 0);

    // T2: set pixels at both ends, one of them negative
    mem[0] = 32'sd1; mem[783] = -32'sd5;
    scan();
    chk("t2_xfers", n_xfer, 784);
    chk("t2_data", bad_data, 0);
    chk("t2_last", bad_last, 0);
    chk("t2_set_count", set_count, 2);

    // T3: backpressure on index 5 for 10 cycles
    bp_idx = 5; bp_len = 10;
    scan();
    chk("t3_stable_cycles", bp_stable, 10);
    chk("t3_index", bad_idx, 0);
    chk("t3_xfers", n_xfer, 784);
    chk("t3_done_cycle", done_cyc, 2363);
    clear_knobs();

    // T4: start re-pulsed during the scan
    restart_at = 100;
    scan();
    chk("t4_done_count", n_done, 1);
    chk("t4_done_cycle", done_cyc, 2353);
    chk("t4_index", bad_idx, 0);
    chk("t4_xfers", n_xfer, 784);
    clear_knobs();

    // T5: reset while pixel 300 is offered, then a clean restart
    reset_at = 300;
    scan();
    chk("t5_async_zero", rst_nonzero, 0);
    chk("t5_no_done", n_done, 0);
    chk("t5_xfers_before", n_xfer, 300);
    clear_knobs();
    scan();
    chk("t5_restart_first", first_valid, 3);
    chk("t5_restart_index", bad_idx, 0);
    chk("t5_restart_count", set_count, 2);

    // T6: third set pixel added between scans; start during DONE ignored
    mem[400] = 32'sd7;
    hold_sc = 2; start_on_done = 1;
    scan();
    chk("t6_hold", bad_hold, 0);
    chk("t6_data", bad_data, 0);
    chk("t6_set_count", set_count, 3);
    chk("t6_start_on_done", idle_bad, 0);
    clear_knobs();
    repeat (3) @(negedge clk);
    chk("t6_still_idle", busy, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
